// File: rtl/tap_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register, bypass register and TDO mux.
// Optional TAP_STATE_OUT_EN exports the current FSM state as TAP_STATE[3:0].
module tap_ctrl #(
    parameter int                IR_LEN    = 4,
    parameter logic [IR_LEN-1:0] IDCODE_OP = IR_LEN'(4'b0010)
) (
    input  logic       TCK,
    input  logic       rst,
    input  logic       TMS,
    input  logic       TDI,
    input  logic       BSR_TDO,
    output logic       TDO,
    output logic       TDO_OE,
    output logic       CAPTUREDR,
    output logic       SHIFTDR,
    output logic       UPDATEDR,
    output logic       EXTEST_SELECT,
    output logic       SAMPLE_SELECT,
    output logic       INTEST_SELECT,
    output logic       RUNBIST_SELECT,
    output logic       CLAMP_SELECT,
    output logic       IDCODE_SELECT,
    output logic       USERCODE_SELECT,
    output logic       HIGHZ_SELECT,
    output logic       BYPASS_SELECT
`ifdef TAP_STATE_OUT_EN
    ,output logic [3:0] TAP_STATE
`endif
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    tap_state_e        r_state;
    tap_state_e        w_next;
    logic [IR_LEN-1:0] r_ir;
    logic [IR_LEN-1:0] r_ir_shift;
    logic              r_bypass;
    logic              r_tdo;
    logic              r_tdo_oe;
    logic [8:0]        w_sel;

    always_ff @(posedge TCK or negedge rst) begin
        if (!rst) r_state <= TLR;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            TLR:    w_next = TMS ? TLR    : RTI;
            RTI:    w_next = TMS ? SEL_DR : RTI;
            SEL_DR: w_next = TMS ? SEL_IR : CAP_DR;
            CAP_DR: w_next = TMS ? EX1_DR : SH_DR;
            SH_DR:  w_next = TMS ? EX1_DR : SH_DR;
            EX1_DR: w_next = TMS ? UPD_DR : PAU_DR;
            PAU_DR: w_next = TMS ? EX2_DR : PAU_DR;
            EX2_DR: w_next = TMS ? UPD_DR : SH_DR;
            UPD_DR: w_next = TMS ? SEL_DR : RTI;
            SEL_IR: w_next = TMS ? TLR    : CAP_IR;
            CAP_IR: w_next = TMS ? EX1_IR : SH_IR;
            SH_IR:  w_next = TMS ? EX1_IR : SH_IR;
            EX1_IR: w_next = TMS ? UPD_IR : PAU_IR;
            PAU_IR: w_next = TMS ? EX2_IR : PAU_IR;
            EX2_IR: w_next = TMS ? UPD_IR : SH_IR;
            UPD_IR: w_next = TMS ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    // Select vector order: EXTEST, SAMPLE, INTEST, RUNBIST, CLAMP, IDCODE, USERCODE, HIGHZ, BYPASS
    always_comb begin
        CAPTUREDR = (r_state == CAP_DR);
        SHIFTDR   = (r_state == SH_DR);
        UPDATEDR  = (r_state == UPD_DR);
        w_sel     = '0;
        case (r_ir)
            IR_LEN'(4'd0): w_sel[8] = 1'b1;
            IR_LEN'(4'd1): w_sel[7] = 1'b1;
            IR_LEN'(4'd3): w_sel[6] = 1'b1;
            IR_LEN'(4'd4): w_sel[5] = 1'b1;
            IR_LEN'(4'd5): w_sel[4] = 1'b1;
            IR_LEN'(4'd2): w_sel[3] = 1'b1;
            IR_LEN'(4'd6): w_sel[2] = 1'b1;
            IR_LEN'(4'd7): w_sel[1] = 1'b1;
            default:       w_sel[0] = 1'b1;
        endcase
    end

    assign {EXTEST_SELECT, SAMPLE_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT,
            IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT, BYPASS_SELECT} = w_sel;

    // ir only loads from the shift register in UPD_IR, so an aborted scan never reaches it
    always_ff @(posedge TCK or negedge rst) begin
        if (!rst) begin
            r_ir       <= IDCODE_OP;
            r_ir_shift <= '0;
            r_bypass   <= 1'b0;
        end else begin
            case (r_state)
                TLR:    r_ir       <= IDCODE_OP;
                CAP_IR: r_ir_shift <= IR_LEN'(2'b01);
                SH_IR:  r_ir_shift <= {TDI, r_ir_shift[IR_LEN-1:1]};
                UPD_IR: r_ir       <= r_ir_shift;
                CAP_DR: if (BYPASS_SELECT) r_bypass <= 1'b0;
                SH_DR:  if (BYPASS_SELECT) r_bypass <= TDI;
                default: ;
            endcase
        end
    end

    always_ff @(negedge TCK or negedge rst) begin
        if (!rst) begin
            r_tdo    <= 1'b0;
            r_tdo_oe <= 1'b0;
        end else begin
            case (r_state)
                SH_IR: begin
                    r_tdo    <= r_ir_shift[0];
                    r_tdo_oe <= 1'b1;
                end
                SH_DR: begin
                    r_tdo    <= BYPASS_SELECT ? r_bypass : BSR_TDO;
                    r_tdo_oe <= 1'b1;
                end
                default: r_tdo_oe <= 1'b0;
            endcase
        end
    end

    assign TDO    = r_tdo;
    assign TDO_OE = r_tdo_oe;

`ifdef TAP_STATE_OUT_EN
    assign TAP_STATE = r_state;
`else
    // state encoding stays internal
`endif

endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: a reference TAP model pushes expected TDO bits,
// popped at each falling TCK edge; strobes, selects and TDO_OE are checked every cycle.
module tb_tap_ctrl;

    localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_CAP_DR = 4'd3, S_SH_DR = 4'd4,
                           S_UPD_DR = 4'd8, S_CAP_IR = 4'd10, S_SH_IR = 4'd11, S_UPD_IR = 4'd15;
    localparam logic [8:0] SEL_IDCODE = 9'b000001000, SEL_BYPASS = 9'b000000001;

    logic TCK = 1'b0;
    logic rst = 1'b1;
    logic TMS = 1'b1, TDI = 1'b0, BSR_TDO = 1'b0;
    logic TDO, TDO_OE, CAPTUREDR, SHIFTDR, UPDATEDR;
    logic EXTEST_SELECT, SAMPLE_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT;
    logic IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT, BYPASS_SELECT;

    tap_ctrl dut (
        .TCK(TCK), .rst(rst), .TMS(TMS), .TDI(TDI), .BSR_TDO(BSR_TDO),
        .TDO(TDO), .TDO_OE(TDO_OE),
        .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
        .EXTEST_SELECT(EXTEST_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
        .INTEST_SELECT(INTEST_SELECT), .RUNBIST_SELECT(RUNBIST_SELECT),
        .CLAMP_SELECT(CLAMP_SELECT), .IDCODE_SELECT(IDCODE_SELECT),
        .USERCODE_SELECT(USERCODE_SELECT), .HIGHZ_SELECT(HIGHZ_SELECT),
        .BYPASS_SELECT(BYPASS_SELECT)
    );

    always #5 TCK = ~TCK;

    int n_vec = 0;
    int n_err = 0;
    logic q_exp[$];

    logic [3:0] m_state;
    logic [3:0] m_ir, m_irs;
    logic       m_byp, m_tdo;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] nxt(input logic [3:0] s, input logic t);
        case (s)
            4'd0:  return t ? 4'd0  : 4'd1;
            4'd1:  return t ? 4'd2  : 4'd1;
            4'd2:  return t ? 4'd9  : 4'd3;
            4'd3:  return t ? 4'd5  : 4'd4;
            4'd4:  return t ? 4'd5  : 4'd4;
            4'd5:  return t ? 4'd8  : 4'd6;
            4'd6:  return t ? 4'd7  : 4'd6;
            4'd7:  return t ? 4'd8  : 4'd4;
            4'd8:  return t ? 4'd2  : 4'd1;
            4'd9:  return t ? 4'd0  : 4'd10;
            4'd10: return t ? 4'd12 : 4'd11;
            4'd11: return t ? 4'd12 : 4'd11;
            4'd12: return t ? 4'd15 : 4'd13;
            4'd13: return t ? 4'd14 : 4'd13;
            4'd14: return t ? 4'd15 : 4'd11;
            default: return t ? 4'd2 : 4'd1;
        endcase
    endfunction

    function automatic logic [8:0] exp_sel(input logic [3:0] op);
        case (op)
            4'b0000: return 9'b100000000;
            4'b0001: return 9'b010000000;
            4'b0011: return 9'b001000000;
            4'b0100: return 9'b000100000;
            4'b0101: return 9'b000010000;
            4'b0010: return 9'b000001000;
            4'b0110: return 9'b000000100;
            4'b0111: return 9'b000000010;
            default: return 9'b000000001;
        endcase
    endfunction

    function automatic logic [8:0] dut_sel();
        return {EXTEST_SELECT, SAMPLE_SELECT, INTEST_SELECT, RUNBIST_SELECT, CLAMP_SELECT,
                IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT, BYPASS_SELECT};
    endfunction

    task automatic model_reset();
        m_state = S_TLR; m_ir = 4'b0010; m_irs = 4'b0000; m_byp = 1'b0; m_tdo = 1'b0;
        q_exp.delete();
    endtask

    // One TCK cycle: drive, advance the model, push expected TDO, check after each edge
    task automatic step(input logic tms, input logic tdi, input logic bsr);
        logic bsel;
        TMS = tms; TDI = tdi; BSR_TDO = bsr;
        bsel = (exp_sel(m_ir) == SEL_BYPASS);
        case (m_state)
            S_TLR:    m_ir  = 4'b0010;
            S_CAP_IR: m_irs = 4'b0001;
            S_SH_IR:  m_irs = {tdi, m_irs[3:1]};
            S_UPD_IR: m_ir  = m_irs;
            S_CAP_DR: if (bsel) m_byp = 1'b0;
            S_SH_DR:  if (bsel) m_byp = tdi;
            default: ;
        endcase
        m_state = nxt(m_state, tms);
        if (m_state == S_SH_IR)      q_exp.push_back(m_irs[0]);
        else if (m_state == S_SH_DR) q_exp.push_back((exp_sel(m_ir) == SEL_BYPASS) ? m_byp : bsr);
        @(posedge TCK); #1;
        check("strobes", {CAPTUREDR, SHIFTDR, UPDATEDR},
              {m_state == S_CAP_DR, m_state == S_SH_DR, m_state == S_UPD_DR});
        check("select", dut_sel(), exp_sel(m_ir));
        @(negedge TCK); #1;
        check("tdo_oe", TDO_OE, (m_state == S_SH_IR) || (m_state == S_SH_DR));
        if (q_exp.size() != 0) m_tdo = q_exp.pop_front();
        check("tdo", TDO, m_tdo);
    endtask

    // From RTI: full IR scan of op (LSB first), back to RTI
    task automatic ir_scan(input logic [3:0] op);
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 4; i++) step(i == 3, op[i], 0);
        step(1, 0, 0); step(0, 0, 0);
    endtask

    // From RTI: DR scan of n bits, optional 3-cycle pause after bit pause_at
    task automatic dr_scan(input logic [15:0] bits, input int n, input int pause_at);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < n; i++) begin
            step((i == n - 1) || (i == pause_at), bits[i], 1'($urandom_range(0, 1)));
            if (i == pause_at && i != n - 1) begin
                step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
                step(1, 0, 0); step(0, 0, 1'($urandom_range(0, 1)));
            end
        end
        step(1, 0, 0); step(0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tdo"}, TDO, 1'b0);
        check({tag, "_oe"}, TDO_OE, 1'b0);
        check({tag, "_strobes"}, {CAPTUREDR, SHIFTDR, UPDATEDR}, 3'b000);
        check({tag, "_sel"}, dut_sel(), SEL_IDCODE);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset_outputs("por");
        @(negedge TCK); #1 rst = 1'b1;

        // Reach SH_DR, then five TMS=1 back to TLR
        step(0, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("tlr_state", m_state, S_TLR);
        check("tlr_sel", dut_sel(), SEL_IDCODE);
        step(0, 0, 0);

        // IR = 1111 -> BYPASS; TDO shows captured 01 pattern
        ir_scan(4'b1111);
        check("byp_sel", dut_sel(), SEL_BYPASS);
        dr_scan(16'b1101, 4, -1);

        // Undefined opcode, then IDCODE with BSR passthrough
        ir_scan(4'b1010);
        check("undef_sel", dut_sel(), SEL_BYPASS);
        ir_scan(4'b0010);
        check("idcode_sel", dut_sel(), SEL_IDCODE);
        dr_scan(16'h0, 6, -1);

        // Every opcode decodes to exactly one select
        for (int op = 0; op < 16; op++) ir_scan(4'(op));

        // Bypass scan paused mid-stream
        ir_scan(4'b1111);
        dr_scan(16'b10110110, 8, 3);

        // Reset two bits into an IR scan
        step(1, 0, 0); step(1, 0, 0); step(0, 0, 0); step(0, 1, 0);
        step(0, 1, 0); step(0, 1, 0);
        rst = 1'b0;
        #1 check_reset_outputs("mid");
        model_reset();
        @(posedge TCK); @(negedge TCK); #1 rst = 1'b1;
        step(1, 0, 0); step(0, 0, 0);
        check("post_sel", dut_sel(), SEL_IDCODE);
        dr_scan(16'h0, 4, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
